// File: rtl/wfm_trigger_mc.sv
// Multi-channel waveform trigger: per-channel threshold and discriminator capture,
// edge-detected source arbitration with holdoff and a saturating suppressed-trigger count.
module wfm_trigger_mc #(
   parameter int unsigned P_N_CHAN        = 4,
   parameter int unsigned P_ADC_WIDTH     = 12,
   parameter int unsigned P_DISCR_WIDTH   = 8,
   parameter int unsigned P_HOLDOFF_WIDTH = 16,
   parameter int unsigned P_CNT_WIDTH     = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [P_N_CHAN*P_ADC_WIDTH-1:0]     adc_stream_in,
   input  logic [P_N_CHAN*P_DISCR_WIDTH-1:0]   discr_stream_in,
   output logic [P_N_CHAN*P_ADC_WIDTH-1:0]     adc_stream_out,
   output logic [P_N_CHAN*P_DISCR_WIDTH-1:0]   discr_stream_out,
   input  logic [P_ADC_WIDTH-1:0]              thr,
   input  logic                                gt,
   input  logic                                et,
   input  logic                                lt,
   input  logic [P_N_CHAN-1:0]                 chan_mask,
   input  logic [$clog2(P_N_CHAN+1)-1:0]       mult_min,
   input  logic                                thresh_trig_en,
   input  logic                                discr_trig_en,
   input  logic                                ext_trig_en,
   input  logic                                discr_trig_pol,
   input  logic                                run,
   input  logic                                ext_run,
   input  logic [P_HOLDOFF_WIDTH-1:0]          holdoff,
   input  logic                                cnt_clr,
   output logic                                trig,
   output logic [1:0]                          trig_src,
   output logic [P_N_CHAN-1:0]                 trig_chan,
   output logic                                thresh_tot,
   output logic                                holdoff_active,
   output logic [P_CNT_WIDTH-1:0]              suppressed_cnt
);

   localparam int unsigned MW = $clog2(P_N_CHAN + 1);
   localparam logic [1:0] SRC_THRESH = 2'd0;
   localparam logic [1:0] SRC_EXT    = 2'd1;
   localparam logic [1:0] SRC_SW     = 2'd2;
   localparam logic [1:0] SRC_DISCR  = 2'd3;

   logic [P_N_CHAN-1:0]               thr_c, dsc_c, thr_q, dsc_q, thr_m;
   logic                              run_q, ext_q;
   logic [P_N_CHAN*P_ADC_WIDTH-1:0]   adc_d1;
   logic [P_N_CHAN*P_DISCR_WIDTH-1:0] discr_d1;
   logic                              mcond_p, dcond_p, run_p, ext_p;
   logic [MW-1:0]                     pop, min_eff;
   logic                              mcond, dcond;
   logic                              c_thr, c_ext, c_sw, c_dsc, any_c, busy;
   logic [1:0]                        src_c;
   logic [P_HOLDOFF_WIDTH-1:0]        hcnt;

   // Stage-1 per-channel compare and discriminator activity
   always_comb begin
      thr_c = '0;
      dsc_c = '0;
      for (int unsigned c = 0; c < P_N_CHAN; c++) begin
         thr_c[c] = (gt && (adc_stream_in[c*P_ADC_WIDTH +: P_ADC_WIDTH] >  thr)) ||
                    (et && (adc_stream_in[c*P_ADC_WIDTH +: P_ADC_WIDTH] == thr)) ||
                    (lt && (adc_stream_in[c*P_ADC_WIDTH +: P_ADC_WIDTH] <  thr));
         dsc_c[c] = |(discr_stream_in[c*P_DISCR_WIDTH +: P_DISCR_WIDTH] ~^
                      {P_DISCR_WIDTH{discr_trig_pol}});
      end
   end

   // Stage-2 conditions, rising-edge candidates and priority pick
   always_comb begin
      thr_m   = thr_q & chan_mask;
      pop     = '0;
      for (int unsigned c = 0; c < P_N_CHAN; c++) begin
         pop = pop + MW'(thr_m[c]);
      end
      min_eff = (mult_min == '0) ? MW'(1) : mult_min;
      mcond   = (pop >= min_eff);
      dcond   = |(dsc_q & chan_mask);
      c_thr   = mcond & ~mcond_p & thresh_trig_en;
      c_ext   = ext_q & ~ext_p & ext_trig_en;
      c_sw    = run_q & ~run_p;
      c_dsc   = dcond & ~dcond_p & discr_trig_en;
      any_c   = c_thr | c_ext | c_sw | c_dsc;
      busy    = (hcnt != '0);
      src_c   = SRC_THRESH;
      if (c_sw)       src_c = SRC_SW;
      else if (c_ext) src_c = SRC_EXT;
      else if (c_dsc) src_c = SRC_DISCR;
   end

   // History resets high so a condition already true at release cannot fire
   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q            <= '1;
         dsc_q            <= '1;
         run_q            <= 1'b1;
         ext_q            <= 1'b1;
         mcond_p          <= 1'b1;
         dcond_p          <= 1'b1;
         run_p            <= 1'b1;
         ext_p            <= 1'b1;
         adc_d1           <= '0;
         discr_d1         <= '0;
         adc_stream_out   <= '0;
         discr_stream_out <= '0;
         trig             <= 1'b0;
         trig_src         <= '0;
         trig_chan        <= '0;
         thresh_tot       <= 1'b0;
         holdoff_active   <= 1'b0;
         hcnt             <= '0;
         suppressed_cnt   <= '0;
      end else begin
         thr_q            <= thr_c;
         dsc_q            <= dsc_c;
         run_q            <= run;
         ext_q            <= ext_run;
         mcond_p          <= mcond;
         dcond_p          <= dcond;
         run_p            <= run_q;
         ext_p            <= ext_q;
         adc_d1           <= adc_stream_in;
         discr_d1         <= discr_stream_in;
         adc_stream_out   <= adc_d1;
         discr_stream_out <= discr_d1;
         thresh_tot       <= |thr_m;
         holdoff_active   <= busy;
         trig             <= any_c & ~busy;
         if (any_c && !busy) begin
            trig_src  <= src_c;
            trig_chan <= thr_m;
            hcnt      <= holdoff;
         end else if (busy) begin
            hcnt <= hcnt - P_HOLDOFF_WIDTH'(1);
         end
         // Discards during holdoff are counted per cycle, not per source
         if (cnt_clr) begin
            suppressed_cnt <= P_CNT_WIDTH'(any_c & busy);
         end else if (any_c && busy && (suppressed_cnt != '1)) begin
            suppressed_cnt <= suppressed_cnt + P_CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_wfm_trigger_mc.sv
// Bench for wfm_trigger_mc: directed corner sequences, a vector table for source
// priority and holdoff, then randomized traffic against a time-based reference model.
module tb_wfm_trigger_mc;

   localparam int unsigned N   = 4;
   localparam int unsigned AW  = 12;
   localparam int unsigned DW  = 8;
   localparam int unsigned HW  = 16;
   localparam int unsigned CW  = 2;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic              clk, rst;
   logic [N*AW-1:0]   adc_stream_in, adc_stream_out;
   logic [N*DW-1:0]   discr_stream_in, discr_stream_out;
   logic [AW-1:0]     thr;
   logic              gt, et, lt;
   logic [N-1:0]      chan_mask;
   logic [2:0]        mult_min;
   logic              thresh_trig_en, discr_trig_en, ext_trig_en, discr_trig_pol;
   logic              run, ext_run;
   logic [HW-1:0]     holdoff;
   logic              cnt_clr;
   logic              trig;
   logic [1:0]        trig_src;
   logic [N-1:0]      trig_chan;
   logic              thresh_tot, holdoff_active;
   logic [CW-1:0]     suppressed_cnt;

   wfm_trigger_mc #(.P_N_CHAN(N), .P_ADC_WIDTH(AW), .P_DISCR_WIDTH(DW),
                    .P_HOLDOFF_WIDTH(HW), .P_CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .adc_stream_in(adc_stream_in), .discr_stream_in(discr_stream_in),
      .adc_stream_out(adc_stream_out), .discr_stream_out(discr_stream_out),
      .thr(thr), .gt(gt), .et(et), .lt(lt), .chan_mask(chan_mask), .mult_min(mult_min),
      .thresh_trig_en(thresh_trig_en), .discr_trig_en(discr_trig_en),
      .ext_trig_en(ext_trig_en), .discr_trig_pol(discr_trig_pol),
      .run(run), .ext_run(ext_run), .holdoff(holdoff), .cnt_clr(cnt_clr),
      .trig(trig), .trig_src(trig_src), .trig_chan(trig_chan), .thresh_tot(thresh_tot),
      .holdoff_active(holdoff_active), .suppressed_cnt(suppressed_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_adc(input int ch, input logic [AW-1:0] v);
      adc_stream_in[ch*AW +: AW] = v;
   endtask

   task automatic cfg_default();
      thr = 12'd100; gt = 1'b1; et = 1'b0; lt = 1'b0;
      chan_mask = 4'hF; mult_min = 3'd1;
      thresh_trig_en = 1'b1; discr_trig_en = 1'b0; ext_trig_en = 1'b0; discr_trig_pol = 1'b1;
      run = 1'b0; ext_run = 1'b0; holdoff = '0; cnt_clr = 1'b0;
      discr_stream_in = '0;
      for (int c = 0; c < int'(N); c++) set_adc(c, 12'd50);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk) rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model (absolute-time holdoff) ----------------
   int           cyc = 0;
   logic         e_trig, e_tot, e_hact;
   logic [1:0]   e_src;
   logic [N-1:0] e_chan;
   int           e_cnt;
   logic [N*AW-1:0] e_adc, m_adc_d1;
   logic [N*DW-1:0] e_dsc, m_dsc_d1;
   logic [N-1:0] m_thr, m_dsc;
   logic         m_run, m_ext, p_m, p_d, p_r, p_e;
   logic         m_valid;
   int           m_last, m_h;

   function automatic logic [N-1:0] thr_eval(input logic [N*AW-1:0] a);
      logic [N-1:0] r;
      int s;
      for (int c = 0; c < int'(N); c++) begin
         s = int'(a[c*AW +: AW]);
         r[c] = (gt && s > int'(thr)) || (et && s == int'(thr)) || (lt && s < int'(thr));
      end
      return r;
   endfunction

   function automatic logic [N-1:0] dsc_eval(input logic [N*DW-1:0] d);
      logic [N-1:0] r;
      logic [DW-1:0] b;
      for (int c = 0; c < int'(N); c++) begin
         b = d[c*DW +: DW];
         r[c] = discr_trig_pol ? (b != 8'h00) : (b != 8'hFF);
      end
      return r;
   endfunction

   // Expected outputs for the cycle after the inputs just driven
   task automatic model_step();
      logic mc, dc, ct, ce, cs, cd, any_c, blocked;
      int need;
      if (rst) begin
         e_trig = 0; e_src = '0; e_chan = '0; e_tot = 0; e_hact = 0; e_cnt = 0;
         e_adc = '0; e_dsc = '0; m_adc_d1 = '0; m_dsc_d1 = '0; m_valid = 0;
         m_thr = '1; m_dsc = '1; m_run = 1; m_ext = 1;
         p_m = 1; p_d = 1; p_r = 1; p_e = 1;
         return;
      end
      need  = (mult_min == 0) ? 1 : int'(mult_min);
      mc    = $countones(m_thr & chan_mask) >= need;
      dc    = |(m_dsc & chan_mask);
      ct    = thresh_trig_en && mc && !p_m;
      ce    = ext_trig_en && m_ext && !p_e;
      cs    = m_run && !p_r;
      cd    = discr_trig_en && dc && !p_d;
      any_c = ct || ce || cs || cd;
      blocked = m_valid && (cyc + 1 > m_last) && (cyc + 1 <= m_last + m_h);
      e_hact  = blocked;
      e_trig  = any_c && !blocked;
      if (e_trig) begin
         e_src   = cs ? 2'd2 : ce ? 2'd1 : cd ? 2'd3 : 2'd0;
         e_chan  = m_thr & chan_mask;
         m_valid = 1; m_last = cyc + 1; m_h = int'(holdoff);
      end
      if (cnt_clr) e_cnt = (any_c && blocked) ? 1 : 0;
      else if (any_c && blocked && e_cnt < CNT_MAX) e_cnt++;
      e_tot = |(m_thr & chan_mask);
      e_adc = m_adc_d1; m_adc_d1 = adc_stream_in;
      e_dsc = m_dsc_d1; m_dsc_d1 = discr_stream_in;
      p_m = mc; p_d = dc; p_r = m_run; p_e = m_ext;
      m_thr = thr_eval(adc_stream_in); m_dsc = dsc_eval(discr_stream_in);
      m_run = run; m_ext = ext_run;
   endtask

   // ---------------- source/holdoff vector table ----------------
   typedef struct {
      logic          run;
      logic          ext_run;
      logic [HW-1:0] hold;
      logic          e_trig;
      logic [1:0]    e_src;
      logic          e_hact;
      logic [CW-1:0] e_cnt;
   } vec_t;
   vec_t tbl [23];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic live;
      logic [AW-1:0] v;
      for (int i = 0; i < 23; i++) begin
         tbl[i].run     = 1'b0;
         tbl[i].ext_run = 1'b0;
         tbl[i].hold    = (i < 6) ? 16'd0 : 16'd10;
         tbl[i].e_trig  = 1'b0;
         tbl[i].e_src   = (i < 3) ? 2'd0 : 2'd2;
         tbl[i].e_hact  = ((i >= 9) && (i <= 18)) || (i >= 21);
         tbl[i].e_cnt   = (i >= 13) ? 2'd1 : 2'd0;
      end
      tbl[1].run = 1'b1; tbl[1].ext_run = 1'b1; tbl[3].e_trig = 1'b1;
      tbl[6].run = 1'b1; tbl[11].run = 1'b1; tbl[18].run = 1'b1;
      tbl[8].e_trig = 1'b1; tbl[20].e_trig = 1'b1;

      clk = 1'b0; rst = 1'b1;
      cfg_default();
      repeat (3) @(negedge clk);
      chk("rst_trig", trig, 0);
      chk("rst_src", trig_src, 0);
      chk("rst_chan", trig_chan, 0);
      chk("rst_tot", thresh_tot, 0);
      chk("rst_hact", holdoff_active, 0);
      chk("rst_cnt", suppressed_cnt, 0);
      chk("rst_adc_out", adc_stream_out, 0);
      rst = 1'b0;

      // Single-channel crossing
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("A_idle_trig", trig, 0);
      end
      @(negedge clk); set_adc(2, 12'd150);
      @(negedge clk); chk("A_n1_trig", trig, 0);
      @(negedge clk);
      chk("A_trig", trig, 1);
      chk("A_src", trig_src, 0);
      chk("A_chan", trig_chan, 4'b0100);
      chk("A_adc_ch2", adc_stream_out[2*AW +: AW], 150);
      chk("A_tot", thresh_tot, 1);
      @(negedge clk);
      chk("A_n3_trig", trig, 0);
      chk("A_chan_hold", trig_chan, 4'b0100);
      mult_min = 3'd2; set_adc(2, 12'd50);

      // Multiplicity of two
      repeat (4) @(negedge clk);
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("B_trig_%0d", i), trig, (i == 7));
         if (i == 7) chk("B_chan", trig_chan, 4'b1001);
         if (i == 0) set_adc(0, 12'd150);
         if (i == 5) set_adc(3, 12'd150);
      end

      // Source priority and holdoff table
      cfg_default(); thresh_trig_en = 1'b0; ext_trig_en = 1'b1;
      do_reset(2);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         chk($sformatf("T%0d_trig", i), trig, tbl[i].e_trig);
         chk($sformatf("T%0d_src", i), trig_src, tbl[i].e_src);
         chk($sformatf("T%0d_hact", i), holdoff_active, tbl[i].e_hact);
         chk($sformatf("T%0d_cnt", i), suppressed_cnt, tbl[i].e_cnt);
         run = tbl[i].run; ext_run = tbl[i].ext_run; holdoff = tbl[i].hold;
      end

      // Saturation and clear of the suppressed counter
      cfg_default(); thresh_trig_en = 1'b0; holdoff = 16'd100;
      do_reset(2);
      repeat (3) @(negedge clk);
      for (int c = 0; c <= 22; c++) begin
         @(negedge clk);
         if (c == 2)  chk("D_trig", trig, 1);
         if (c == 6)  chk("D_cnt1", suppressed_cnt, 1);
         if (c == 8)  chk("D_cnt2", suppressed_cnt, 2);
         if (c == 17) chk("D_sat", suppressed_cnt, 3);
         if (c == 19) chk("D_sat_hold", suppressed_cnt, 3);
         if (c == 20) chk("D_clr_discard", suppressed_cnt, 1);
         if (c == 22) chk("D_clr", suppressed_cnt, 0);
         run     = (c == 0) || (c >= 4 && c <= 14 && (c % 2 == 0)) || (c == 18);
         cnt_clr = (c == 19) || (c == 21);
      end

      // Condition held high through reset
      cfg_default();
      set_adc(0, 12'd150);
      do_reset(3);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); chk("E_no_trig", trig, 0);
      end
      chk("E_tot", thresh_tot, 1);
      set_adc(0, 12'd50);
      repeat (3) @(negedge clk);
      @(negedge clk); set_adc(0, 12'd150);
      @(negedge clk); chk("E_m1_trig", trig, 0);
      @(negedge clk); chk("E_m2_trig", trig, 1);
      chk("E_chan", trig_chan, 4'b0001);

      // Randomized traffic against the reference model
      live = 1'b0;
      for (int blk = 0; blk < 12; blk++) begin
         for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (live) begin
               chk("R_trig", trig, e_trig);
               chk("R_src", trig_src, e_src);
               chk("R_chan", trig_chan, e_chan);
               chk("R_tot", thresh_tot, e_tot);
               chk("R_hact", holdoff_active, e_hact);
               chk("R_cnt", suppressed_cnt, e_cnt);
               chk("R_adc", adc_stream_out, e_adc);
               chk("R_dsc", discr_stream_out, e_dsc);
            end
            live = 1'b1;
            if (k == 0) begin
               thr = AW'($urandom_range(200, 3800));
               gt = 1'($urandom); et = 1'($urandom); lt = 1'($urandom);
               chan_mask = N'($urandom);
               mult_min = 3'($urandom_range(0, 5));
               thresh_trig_en = ($urandom_range(0, 3) != 0);
               discr_trig_en  = ($urandom_range(0, 3) != 0);
               ext_trig_en    = ($urandom_range(0, 3) != 0);
               discr_trig_pol = 1'($urandom);
               holdoff = HW'($urandom_range(0, 20));
            end
            rst = (k < 2) || ($urandom_range(0, 199) == 0);
            for (int c = 0; c < int'(N); c++) begin
               if ($urandom_range(0, 2) == 0) begin
                  if ($urandom_range(0, 3) == 0) v = AW'($urandom);
                  else v = thr + AW'($urandom_range(0, 4)) - AW'(2);
                  set_adc(c, v);
               end
               if ($urandom_range(0, 3) == 0) begin
                  if ($urandom_range(0, 1) == 0) discr_stream_in[c*DW +: DW] = {DW{~discr_trig_pol}};
                  else discr_stream_in[c*DW +: DW] = DW'($urandom);
               end
            end
            if ($urandom_range(0, 5) == 0) run = ~run;
            if ($urandom_range(0, 5) == 0) ext_run = ~ext_run;
            cnt_clr = ($urandom_range(0, 15) == 0);
            cyc++;
            model_step();
         end
      end
      @(negedge clk);
      chk("R_trig_last", trig, e_trig);
      chk("R_cnt_last", suppressed_cnt, e_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wfm_trigger_mc.md
WFM_TRIGGER_MC -- requirements
Module: wfm_trigger_mc

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
  P_N_CHAN  4  number of ADC channels
  P_ADC_WIDTH  12  bits per ADC sample
  P_DISCR_WIDTH  8  discriminator bits per channel per clock
  P_HOLDOFF_WIDTH  16  holdoff counter width
  P_CNT_WIDTH  16  suppressed-trigger counter width
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  sole clock
  rst  in  1  synchronous active-high reset
  adc_stream_in  in  P_N_CHAN*P_ADC_WIDTH  channel c at bits [c*P_ADC_WIDTH +: P_ADC_WIDTH]
  discr_stream_in  in  P_N_CHAN*P_DISCR_WIDTH  packed the same way
  adc_stream_out  out  P_N_CHAN*P_ADC_WIDTH  input delayed 2 cycles
  discr_stream_out  out  P_N_CHAN*P_DISCR_WIDTH  input delayed 2 cycles
  thr  in  P_ADC_WIDTH  threshold, unsigned, shared by all channels
  gt, et, lt  in  1 each  compare-mode selects
  chan_mask  in  P_N_CHAN  per-channel enable for threshold and discr triggers
  mult_min  in  clog2(P_N_CHAN+1)  required channel multiplicity; 0 is treated as 1
  thresh_trig_en, discr_trig_en, ext_trig_en  in  1 each  source enables
  discr_trig_pol  in  1  discr active level
  run  in  1  software trigger level
  ext_run  in  1  external trigger level
  holdoff  in  P_HOLDOFF_WIDTH  dead cycles after each trigger
  cnt_clr  in  1  clears suppressed_cnt
  trig  out  1  one-cycle trigger pulse
  trig_src  out  2  0 = thresh, 1 = ext, 2 = sw, 3 = discr
  trig_chan  out  P_N_CHAN  masked per-channel threshold state at trigger
  thresh_tot  out  1  OR of masked per-channel threshold states
  holdoff_active  out  1  high while triggers are suppressed
  suppressed_cnt  out  P_CNT_WIDTH  number of triggers discarded during holdoff, saturating

Function
REQ-003 Stage 1 SHALL register, for each channel c, thr_q[c] = (gt & s>thr) | (et & s==thr) | (lt & s<thr), where s is the unsigned sample of channel c.
REQ-004 Stage 1 SHALL register dsc_q[c] = 1 when any discr bit of channel c equals discr_trig_pol.
REQ-005 Stage 1 SHALL register run_q = run and ext_q = ext_run.
REQ-006 Multiplicity condition: mcond = popcount(thr_q & chan_mask) >= max(mult_min, 1).
REQ-007 Discr condition: dcond = OR(dsc_q & chan_mask).
REQ-008 Each condition SHALL produce a candidate only on its 0->1 transition, compared against its stage-2 previous value.
REQ-009 Candidates SHALL be: thresh = mcond rising & thresh_trig_en; ext = ext_q rising & ext_trig_en; sw = run_q rising (always enabled); discr = dcond rising & discr_trig_en.
REQ-010 When several candidates occur in one cycle, priority SHALL be sw > ext > discr > thresh; exactly one trig pulse is issued, and trig_src names the winner.
REQ-011 trig, trig_src and trig_chan SHALL be registered outputs, so trig asserts 2 cycles after the input sample that caused it.
REQ-012 trig SHALL align with that sample on adc_stream_out and discr_stream_out.
REQ-013 trig_src and trig_chan SHALL hold their values until the next trig.
REQ-014 thresh_tot SHALL be registered from OR(thr_q & chan_mask), giving the same 2-cycle latency.
REQ-015 Holdoff: on trig, a counter SHALL load holdoff; while the counter is nonzero it decrements by 1 per cycle and holdoff_active = 1.
REQ-016 With holdoff = 0 there SHALL be no suppression.
REQ-017 With holdoff = N, the earliest next trig SHALL be N+1 cycles after the previous one.
REQ-018 A candidate arriving while holdoff_active SHALL be discarded, not queued; suppressed_cnt increments by 1 per cycle containing at least one discarded candidate and saturates at all-ones.
REQ-019 cnt_clr SHALL zero suppressed_cnt; a discard in the same cycle as cnt_clr makes the result 1.
REQ-020 Edge-detect history SHALL update every cycle regardless of holdoff, so a condition that stays high through holdoff does not fire when holdoff ends.
REQ-021 Configuration inputs SHALL be used without internal registration; a change takes effect on the next stage-1 capture.

Reset
REQ-022 On rst, all outputs, stream delay registers, the holdoff counter and suppressed_cnt SHALL go to 0.
REQ-023 On rst, stage-1 and previous-condition registers SHALL go to 1, so a condition already true at reset release produces no trigger.
REQ-024 rst asserted mid-holdoff SHALL abort the holdoff immediately; the first trig is possible 3 cycles after rst deasserts.

Verification
REQ-025 Threshold crossing: P_N_CHAN=4, thr=100, gt=1, mask=4'b1111, mult_min=1; ch2 goes 50->150 at cycle n -> trig=1 at n+2, trig_src=0, trig_chan=4'b0100, adc_stream_out ch2=150 in the same cycle.
REQ-026 Multiplicity: mult_min=2; ch0 crosses at n, ch3 crosses at n+5 -> a single trig at n+7, trig_chan=4'b1001.
REQ-027 Simultaneous sources: run and ext_run rise in the same cycle, ext_trig_en=1 -> one trig, trig_src=2, and no second pulse for ext.
REQ-028 Holdoff: holdoff=10; run pulses at cycles 0, 5 and 12 -> trig at 2 and 14; suppressed_cnt=1; holdoff_active high during cycles 3-12.
REQ-029 Saturation and clear: P_CNT_WIDTH=2, six discards -> suppressed_cnt=3; cnt_clr coinciding with a discard -> 1.
REQ-030 Reset with condition active: hold ch0=150 (thr=100, gt=1) through rst -> no trig after release; ch0 drops to 50, then returns to 150 at cycle m -> trig at m+2.
